ram_cmd_arbiter: RTL and testbench

RAM_CMD_ARBITER -- requirements
Module: ram_cmd_arbiter

---
 rtl/ram_cmd_arbiter.sv | 265 ++++++++++++++++++++++++++
 tb/tb_ram_cmd_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// ram_cmd_arbiter
//
// Two-requester round-robin arbiter that turns one granted access into a
// serial command sequence for a simple RAM.  A write sends an address word
// and a data word.  A read sends an address word and a read-trigger word,
// then waits up to TIMEOUT cycles for the returned byte.  Every command word
// is held valid for two cycles.  A one-cycle DONE state closes each access
// and always separates consecutive RAM transactions.
//
// Parameters
//   ADDR_SIZE    RAM address width
//   TIMEOUT      maximum cycles spent waiting for read data
//
// Ports
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   req0/req1              access request, held until the matching gnt
//   we0/we1                1 = write, 0 = read
//   addr0/addr1            access address
//   wdata0/wdata1          write data
//   gnt0/gnt1              one-cycle pulse: request accepted, operands captured
//   done0/done1            one-cycle pulse: access of that requester complete
//   rdata                  read result, updated in the done cycle of a read
//   err                    pulses with done when a read timed out (rdata = 0)
//   ram_din, ram_rx_valid  command word {opcode[1:0], payload[7:0]} and valid
//   ram_dout, ram_tx_valid read data returned by the RAM and its valid
// ---------------------------------------------------------------------------
module ram_cmd_arbiter #(
   parameter int ADDR_SIZE = 8,
   parameter int TIMEOUT   = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req0,
   input  logic                 req1,
   input  logic                 we0,
   input  logic                 we1,
   input  logic [ADDR_SIZE-1:0] addr0,
   input  logic [ADDR_SIZE-1:0] addr1,
   input  logic [7:0]           wdata0,
   input  logic [7:0]           wdata1,
   output logic                 gnt0,
   output logic                 gnt1,
   output logic                 done0,
   output logic                 done1,
   output logic [7:0]           rdata,
   output logic                 err,
   output logic [9:0]           ram_din,
   output logic                 ram_rx_valid,
   input  logic [7:0]           ram_dout,
   input  logic                 ram_tx_valid
);

   // Timeout counter width; kept at least one bit so TIMEOUT=1 still builds.
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WADDR   = 3'd1,
      WDATA   = 3'd2,
      RADDR   = 3'd3,
      RDATA   = 3'd4,
      WAIT_RD = 3'd5,
      DONE    = 3'd6
   } state_t;

   state_t               state_q;
   state_t               state_d;

   // Two-cycle step counter and read-wait counter, both cleared on state entry.
   logic                 step_q;
   logic [TW-1:0]        tmo_q;

   // Operands captured at grant time.  The access direction is not stored
   // separately: it is already encoded by which branch (WADDR or RADDR) the
   // FSM takes.
   logic                 owner_q;
   logic [ADDR_SIZE-1:0] addr_q;
   logic [7:0]           wdata_q;
   logic [7:0]           addr_payload;

   // last_gnt_q = 1 means requester 1 was granted most recently.
   logic                 last_gnt_q;
   logic                 err_q;
   logic [7:0]           rdata_q;

   // Goes high on the first clock edge after reset.  It holds off any grant
   // until that edge, so a request that is already high during reset cannot
   // produce a gnt pulse while rst_n is still low.
   logic                 armed_q;

   logic                 take_grant;
   logic                 grant_sel;
   logic                 pick1;
   logic                 rd_capture;
   logic                 rd_timeout;

   // The address payload slot is 8 bits wide, so the captured address is
   // zero-extended or truncated to fit it.
   assign addr_payload = 8'(addr_q);
   assign rdata        = rdata_q;

   // Round-robin choice.  A lone request wins outright.  On a tie, the
   // requester that was not granted last wins.
   always_comb begin
      pick1 = 1'b0;
      if (req1 && (!req0 || !last_gnt_q)) begin
         pick1 = 1'b1;
      end
   end

   // Next-state and output decode.  Every output is a function of the
   // current state, plus the request inputs while in IDLE.  This lets reset,
   // which forces IDLE, silence every output at once.
   always_comb begin
      state_d      = state_q;
      gnt0         = 1'b0;
      gnt1         = 1'b0;
      done0        = 1'b0;
      done1        = 1'b0;
      err          = 1'b0;
      ram_din      = 10'h000;
      ram_rx_valid = 1'b0;
      take_grant   = 1'b0;
      grant_sel    = 1'b0;
      rd_capture   = 1'b0;
      rd_timeout   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (armed_q && (req0 || req1)) begin
               take_grant = 1'b1;
               grant_sel  = pick1;
               gnt0       = !pick1;
               gnt1       = pick1;
               if (pick1 ? we1 : we0) begin
                  state_d = WADDR;
               end else begin
                  state_d = RADDR;
               end
            end
         end

         WADDR: begin
            ram_din      = {2'b00, addr_payload};
            ram_rx_valid = 1'b1;
            if (step_q) begin
               state_d = WDATA;
            end
         end

         WDATA: begin
            ram_din      = {2'b01, wdata_q};
            ram_rx_valid = 1'b1;
            if (step_q) begin
               state_d = DONE;
            end
         end

         RADDR: begin
            ram_din      = {2'b10, addr_payload};
            ram_rx_valid = 1'b1;
            if (step_q) begin
               state_d = RDATA;
            end
         end

         RDATA: begin
            ram_din      = {2'b11, 8'h00};
            ram_rx_valid = 1'b1;
            if (step_q) begin
               state_d = WAIT_RD;
            end
         end

         // If data arrives on the final permitted cycle, the data wins over
         // the timeout.
         WAIT_RD: begin
            if (ram_tx_valid) begin
               rd_capture = 1'b1;
               state_d    = DONE;
            end else if (tmo_q == TMO_LAST) begin
               rd_timeout = 1'b1;
               state_d    = DONE;
            end
         end

         DONE: begin
            done0   = !owner_q;
            done1   = owner_q;
            err     = err_q;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register and step/timeout counters.  Both counters are cleared
   // whenever the state changes, so each state starts counting from zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         step_q  <= 1'b0;
         tmo_q   <= '0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         armed_q <= 1'b1;
         if (state_d != state_q) begin
            step_q <= 1'b0;
            tmo_q  <= '0;
         end else begin
            if (state_q == WADDR || state_q == WDATA ||
                state_q == RADDR || state_q == RDATA) begin
               step_q <= 1'b1;
            end
            if (state_q == WAIT_RD) begin
               tmo_q <= tmo_q + TW'(1);
            end
         end
      end
   end

   // Grant-time operand capture and arbitration history.  After this point
   // the requester inputs are not looked at again until the FSM is back in
   // IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_q    <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= 8'h00;
         last_gnt_q <= 1'b1;
      end else if (take_grant) begin
         owner_q    <= grant_sel;
         last_gnt_q <= grant_sel;
         addr_q     <= grant_sel ? addr1 : addr0;
         wdata_q    <= grant_sel ? wdata1 : wdata0;
      end
   end

   // Read result and error flag.  rdata changes only when a read finishes,
   // so it holds its value through later write accesses.  The error flag
   // is cleared by each new grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= 8'h00;
         err_q   <= 1'b0;
      end else begin
         if (take_grant) begin
            err_q <= 1'b0;
         end
         if (rd_capture) begin
            rdata_q <= ram_dout;
         end else if (rd_timeout) begin
            rdata_q <= 8'h00;
            err_q   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_cmd_arbiter
//
// Directed testbench for ram_cmd_arbiter.  As each request is driven, its
// expected grant owner, RAM command words and done record are pushed to
// queues.  A negedge monitor pops each queue and compares when the DUT
// shows a gnt, a valid command word or a done pulse.
// ---------------------------------------------------------------------------
module tb_ram_cmd_arbiter;

   localparam int TIMEOUT = 8;

   logic       clk;
   logic       rst_n;
   logic       req0, req1, we0, we1;
   logic [7:0] addr0, addr1, wdata0, wdata1;
   logic       gnt0, gnt1, done0, done1, err;
   logic [7:0] rdata;
   logic [9:0] ram_din;
   logic       ram_rx_valid;
   logic [7:0] ram_dout;
   logic       ram_tx_valid;

   typedef struct {
      logic       owner;
      logic [7:0] rdata;
      logic       err;
      int         lat;
   } done_t;

   logic       gnt_exp_q[$];
   logic [9:0] cmd_exp_q[$];
   done_t      done_exp_q[$];

   int         pass_cnt    = 0;
   int         fail_cnt    = 0;
   int         check_cnt   = 0;
   int         cyc         = 0;
   int         gnt_cyc     = 0;
   logic [7:0] model_rdata = 8'h00;

   logic       exp_owner;
   logic [9:0] exp_cmd;
   done_t      exp_done;

   ram_cmd_arbiter #(
      .ADDR_SIZE (8),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req0         (req0),
      .req1         (req1),
      .we0          (we0),
      .we1          (we1),
      .addr0        (addr0),
      .addr1        (addr1),
      .wdata0       (wdata0),
      .wdata1       (wdata1),
      .gnt0         (gnt0),
      .gnt1         (gnt1),
      .done0        (done0),
      .done1        (done1),
      .rdata        (rdata),
      .err          (err),
      .ram_din      (ram_din),
      .ram_rx_valid (ram_rx_valid),
      .ram_dout     (ram_dout),
      .ram_tx_valid (ram_tx_valid)
   );

   // Free-running clock and a cycle count used for latency measurement.
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("[TB] FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
      end
   endtask

   // Push the grant owner, command words and done record that one access
   // should produce.  k is the WAIT_RD cycle on which the RAM answers a
   // read; k = 0 means the RAM never answers.
   task automatic expectTxn(input logic who, input logic we, input logic [7:0] addr,
                            input logic [7:0] wdata, input int k, input logic [7:0] rd);
      done_t d;
      gnt_exp_q.push_back(who);
      if (we) begin
         cmd_exp_q.push_back({2'b00, addr});
         cmd_exp_q.push_back({2'b00, addr});
         cmd_exp_q.push_back({2'b01, wdata});
         cmd_exp_q.push_back({2'b01, wdata});
         d.err = 1'b0;
         d.lat = 5;
      end else begin
         cmd_exp_q.push_back({2'b10, addr});
         cmd_exp_q.push_back({2'b10, addr});
         cmd_exp_q.push_back({2'b11, 8'h00});
         cmd_exp_q.push_back({2'b11, 8'h00});
         if (k == 0) begin
            model_rdata = 8'h00;
            d.err       = 1'b1;
            d.lat       = 5 + TIMEOUT;
         end else begin
            model_rdata = rd;
            d.err       = 1'b0;
            d.lat       = 5 + k;
         end
      end
      d.owner = who;
      d.rdata = model_rdata;
      done_exp_q.push_back(d);
   endtask

   task automatic applyStimulus(input logic who, input logic we, input logic [7:0] addr,
                                input logic [7:0] wdata, input int k, input logic [7:0] rd);
      expectTxn(who, we, addr, wdata, k, rd);
      if (who) begin
         req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
      end else begin
         req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
      end
   endtask

   task automatic waitGrant(input logic who);
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if ((who ? gnt1 : gnt0) === 1'b1) seen = 1'b1;
      end
      checkOutput("gnt_seen", 32'(seen), 32'd1);
   endtask

   task automatic waitDone();
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if ((done0 | done1) === 1'b1) seen = 1'b1;
      end
      checkOutput("done_seen", 32'(seen), 32'd1);
   endtask

   // RAM read-side model.  It starts in the first cycle after the grant.
   // During the four command cycles it drives noise (valid with 8'hFF),
   // which the DUT must ignore.  It then answers on WAIT_RD cycle k, or
   // never answers when k = 0.
   task automatic readResponse(input int k, input logic [7:0] d);
      int last;
      last = (k == 0) ? 4 : 4 + k;
      for (int c = 1; c <= last; c++) begin
         if (c > 1) begin
            @(posedge clk); #1;
         end
         ram_tx_valid = (c <= 4) || (k > 0 && c == 4 + k);
         ram_dout     = (k > 0 && c == 4 + k) ? d : 8'hFF;
      end
      @(posedge clk); #1;
      ram_tx_valid = 1'b0;
      ram_dout     = 8'h00;
   endtask

   // Scoreboard monitor: compares DUT outputs against queued expectations.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if ((gnt0 | gnt1) === 1'b1) begin
            checkOutput("gnt_exclusive", 32'(gnt0 & gnt1), 32'd0);
            if (gnt_exp_q.size() == 0) begin
               checkOutput("gnt_unexpected", 32'({gnt1, gnt0}), 32'd0);
            end else begin
               exp_owner = gnt_exp_q.pop_front();
               checkOutput("gnt_owner", 32'(gnt1), 32'(exp_owner));
               gnt_cyc = cyc;
            end
         end
         if (ram_rx_valid === 1'b1) begin
            if (cmd_exp_q.size() == 0) begin
               checkOutput("cmd_unexpected", 32'(ram_din), 32'h3FF);
            end else begin
               exp_cmd = cmd_exp_q.pop_front();
               checkOutput("ram_din", 32'(ram_din), 32'(exp_cmd));
            end
         end
         if ((done0 | done1) === 1'b1) begin
            checkOutput("done_exclusive", 32'(done0 & done1), 32'd0);
            checkOutput("done_gap_rxv", 32'(ram_rx_valid), 32'd0);
            if (done_exp_q.size() == 0) begin
               checkOutput("done_unexpected", 32'({done1, done0}), 32'd0);
            end else begin
               exp_done = done_exp_q.pop_front();
               checkOutput("done_owner", 32'(done1), 32'(exp_done.owner));
               checkOutput("done_rdata", 32'(rdata), 32'(exp_done.rdata));
               checkOutput("done_err", 32'(err), 32'(exp_done.err));
               checkOutput("done_latency", 32'(cyc - gnt_cyc), 32'(exp_done.lat));
            end
         end
         if (err === 1'b1) begin
            checkOutput("err_with_done", 32'(done0 | done1), 32'd1);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence.
   initial begin
      rst_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;
      ram_dout = 8'h00; ram_tx_valid = 1'b0;

      // Reset state, with req0 already high.
      applyStimulus(1'b0, 1'b1, 8'h12, 8'hA5, 0, 8'h00);
      repeat (2) @(negedge clk);
      checkOutput("rst_gnt0", 32'(gnt0), 32'd0);
      checkOutput("rst_gnt1", 32'(gnt1), 32'd0);
      checkOutput("rst_done", 32'({done1, done0}), 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);
      checkOutput("rst_rdata", 32'(rdata), 32'd0);
      checkOutput("rst_ram_din", 32'(ram_din), 32'd0);
      checkOutput("rst_rx_valid", 32'(ram_rx_valid), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Write by req0.  The operands change right after the grant and must
      // not leak into the transaction.
      waitGrant(1'b0);
      @(posedge clk); #1;
      req0 = 1'b0; addr0 = 8'h34; wdata0 = 8'h5A; we0 = 1'b0;
      waitDone();

      // Read by req1; the RAM answers on WAIT_RD cycle 2.
      @(posedge clk); #1;
      applyStimulus(1'b1, 1'b0, 8'h12, 8'h00, 2, 8'hA5);
      waitGrant(1'b1);
      @(posedge clk); #1;
      req1 = 1'b0;
      readResponse(2, 8'hA5);
      waitDone();

      // Read timeout: the RAM never answers.
      @(posedge clk); #1;
      applyStimulus(1'b0, 1'b0, 8'h5C, 8'h00, 0, 8'h00);
      waitGrant(1'b0);
      @(posedge clk); #1;
      req0 = 1'b0;
      readResponse(0, 8'h00);
      waitDone();

      // Answer on the last permitted WAIT_RD cycle: data, no error.
      @(posedge clk); #1;
      applyStimulus(1'b1, 1'b0, 8'h80, 8'h00, TIMEOUT, 8'h3C);
      waitGrant(1'b1);
      @(posedge clk); #1;
      req1 = 1'b0;
      readResponse(TIMEOUT, 8'h3C);
      waitDone();

      // Answer on the first WAIT_RD cycle.
      @(posedge clk); #1;
      applyStimulus(1'b0, 1'b0, 8'h01, 8'h00, 1, 8'hC3);
      waitGrant(1'b0);
      @(posedge clk); #1;
      req0 = 1'b0;
      readResponse(1, 8'hC3);
      waitDone();

      // A write must leave rdata at the last read value.
      @(posedge clk); #1;
      applyStimulus(1'b1, 1'b1, 8'hFE, 8'h0F, 0, 8'h00);
      waitGrant(1'b1);
      @(posedge clk); #1;
      req1 = 1'b0;
      waitDone();

      // Reset in the first WDATA cycle aborts the write with no done pulse.
      @(posedge clk); #1;
      gnt_exp_q.push_back(1'b0);
      cmd_exp_q.push_back(10'h077);
      cmd_exp_q.push_back(10'h077);
      req0 = 1'b1; we0 = 1'b1; addr0 = 8'h77; wdata0 = 8'h99;
      waitGrant(1'b0);
      @(posedge clk); #1;
      req0 = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      checkOutput("abort_rx_valid", 32'(ram_rx_valid), 32'd0);
      checkOutput("abort_ram_din", 32'(ram_din), 32'd0);
      checkOutput("abort_cmd_pending", 32'(cmd_exp_q.size()), 32'd0);
      cmd_exp_q.delete();
      model_rdata = 8'h00;
      applyStimulus(1'b0, 1'b1, 8'h12, 8'hA5, 0, 8'h00);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("gnt_before_edge", 32'(gnt0), 32'd0);
      @(negedge clk);
      checkOutput("gnt_after_release", 32'(gnt0), 32'd1);
      @(posedge clk); #1;
      req0 = 1'b0;
      waitDone();

      // Both requesters held high from reset: grants alternate 0,1,0,1, and
      // each new grant follows the one-cycle DONE gap directly.
      @(posedge clk); #1;
      rst_n = 1'b0;
      model_rdata = 8'h00;
      req0 = 1'b1; we0 = 1'b1; addr0 = 8'h21; wdata0 = 8'h11;
      req1 = 1'b1; we1 = 1'b1; addr1 = 8'h43; wdata1 = 8'h22;
      expectTxn(1'b0, 1'b1, 8'h21, 8'h11, 0, 8'h00);
      expectTxn(1'b1, 1'b1, 8'h43, 8'h22, 0, 8'h00);
      expectTxn(1'b0, 1'b1, 8'h21, 8'h11, 0, 8'h00);
      expectTxn(1'b1, 1'b1, 8'h43, 8'h22, 0, 8'h00);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      waitGrant(1'b0);
      waitDone();
      @(negedge clk);
      checkOutput("rr_second", 32'({gnt1, gnt0}), 32'h2);
      waitDone();
      @(negedge clk);
      checkOutput("rr_third", 32'({gnt1, gnt0}), 32'h1);
      waitDone();
      @(negedge clk);
      checkOutput("rr_fourth", 32'({gnt1, gnt0}), 32'h2);
      @(posedge clk); #1;
      req0 = 1'b0; req1 = 1'b0;
      waitDone();

      repeat (5) @(negedge clk);
      checkOutput("gnt_q_empty", 32'(gnt_exp_q.size()), 32'd0);
      checkOutput("cmd_q_empty", 32'(cmd_exp_q.size()), 32'd0);
      checkOutput("done_q_empty", 32'(done_exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
